// File: rtl/mem_dump_reader.sv
// Post-run memory dump engine: detects a halted core from a stalled fetch PC, then
// reads a fixed window of data memory and streams it out over valid/ready.
module mem_dump_reader #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned START_ADDR  = 0,
  parameter int unsigned DUMP_WORDS  = 8,
  parameter int unsigned HALT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              halted,
  output logic              done
);

  localparam int unsigned IDX_W = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
  localparam int unsigned CNT_W = $clog2(HALT_CYCLES + 1);

  localparam logic [IDX_W-1:0]  LastIdx   = IDX_W'(DUMP_WORDS - 1);
  localparam logic [CNT_W-1:0]  HaltCnt   = CNT_W'(HALT_CYCLES);
  localparam logic [ADDR_W-1:0] StartAddr = ADDR_W'(START_ADDR);

  typedef enum logic [2:0] {StMonitor, StIssue, StWait, StPresent, StDone} state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic [31:0]         r_prev_pc;
  logic                r_prev_vld;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_d;
  logic                r_halted;
  logic [ADDR_W-1:0]   r_cur;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_out_data;
  logic [ADDR_W-1:0]   r_out_addr;
  logic                r_out_last;
  logic                w_halt_set;
  logic                w_handshake;

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_halt_set  = 1'b0;
    w_handshake = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    out_valid   = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      StMonitor: begin
        // The first cycle out of reset only primes r_prev_pc.
        if (r_prev_vld) begin
          if (pc == r_prev_pc) begin
            w_cnt_d = (r_cnt == HaltCnt) ? r_cnt : r_cnt + 1'b1;
          end else begin
            w_cnt_d = '0;
          end
        end
        if (w_cnt_d == HaltCnt) begin
          w_halt_set = 1'b1;
          w_state_d  = StIssue;
        end
      end
      StIssue: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = r_cur;
        w_state_d   = StWait;
      end
      StWait: begin
        w_state_d = StPresent;
      end
      StPresent: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_handshake = 1'b1;
          w_state_d   = r_out_last ? StDone : StIssue;
        end
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
        w_state_d = StMonitor;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StMonitor;
      r_prev_pc  <= '0;
      r_prev_vld <= 1'b0;
      r_cnt      <= '0;
      r_halted   <= 1'b0;
      r_cur      <= StartAddr;
      r_idx      <= '0;
      r_out_data <= '0;
      r_out_addr <= '0;
      r_out_last <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_prev_pc  <= pc;
      r_prev_vld <= 1'b1;
      if (r_state == StMonitor) begin
        r_cnt <= w_cnt_d;
      end
      if (w_halt_set) begin
        r_halted <= 1'b1;
        r_cur    <= StartAddr;
        r_idx    <= '0;
      end
      // Read data returns the cycle after the strobe, i.e. during StWait.
      if (r_state == StWait) begin
        r_out_data <= mem_rd_data;
        r_out_addr <= r_cur;
        r_out_last <= (r_idx == LastIdx);
      end
      if (w_handshake && !r_out_last) begin
        r_cur <= r_cur + 1'b1;
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign out_data = r_out_data;
  assign out_addr = r_out_addr;
  assign out_last = r_out_last;
  assign halted   = r_halted;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: a halt-detect vector table plus dump sequences on three
// configurations (default window, wrapping window, single-word window).
module tb_mem_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst;
  logic [31:0] pc;
  logic [2:0]  rdy;
  logic [2:0]  rd_en, valid, last, halted, done;
  logic [7:0]  rd_addr [3];
  logic [7:0]  oaddr   [3];
  logic [31:0] rd_data [3];
  logic [31:0] odata   [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Synchronous memory model: word i holds 0xA0000000 + i.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rd_en[k]) rd_data[k] <= 32'hA000_0000 + {24'h0, rd_addr[k]};
    end
  end

  mem_dump_reader #(.ADDR_W(8), .DATA_W(32), .START_ADDR(0), .DUMP_WORDS(8),
                    .HALT_CYCLES(2)) u_main (
    .clk(clk), .reset(rst[0]), .pc(pc), .mem_rd_en(rd_en[0]), .mem_rd_addr(rd_addr[0]),
    .mem_rd_data(rd_data[0]), .out_valid(valid[0]), .out_ready(rdy[0]), .out_data(odata[0]),
    .out_addr(oaddr[0]), .out_last(last[0]), .halted(halted[0]), .done(done[0])
  );

  mem_dump_reader #(.ADDR_W(8), .DATA_W(32), .START_ADDR(8'hFE), .DUMP_WORDS(4),
                    .HALT_CYCLES(2)) u_wrap (
    .clk(clk), .reset(rst[1]), .pc(pc), .mem_rd_en(rd_en[1]), .mem_rd_addr(rd_addr[1]),
    .mem_rd_data(rd_data[1]), .out_valid(valid[1]), .out_ready(rdy[1]), .out_data(odata[1]),
    .out_addr(oaddr[1]), .out_last(last[1]), .halted(halted[1]), .done(done[1])
  );

  mem_dump_reader #(.ADDR_W(8), .DATA_W(32), .START_ADDR(5), .DUMP_WORDS(1),
                    .HALT_CYCLES(1)) u_one (
    .clk(clk), .reset(rst[2]), .pc(pc), .mem_rd_en(rd_en[2]), .mem_rd_addr(rd_addr[2]),
    .mem_rd_data(rd_data[2]), .out_valid(valid[2]), .out_ready(rdy[2]), .out_data(odata[2]),
    .out_addr(oaddr[2]), .out_last(last[2]), .halted(halted[2]), .done(done[2])
  );

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        exp_halted;
    logic        exp_rd_en;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic [31:0] p, logic h, logic e);
    vec_t v;
    v.rst = r; v.pc = p; v.exp_halted = h; v.exp_rd_en = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int k);
    check("idle_rd_en", {31'h0, rd_en[k]}, 0);
    check("idle_rd_addr", {24'h0, rd_addr[k]}, 0);
    check("idle_valid", {31'h0, valid[k]}, 0);
    check("idle_data", odata[k], 0);
    check("idle_addr", {24'h0, oaddr[k]}, 0);
    check("idle_last", {31'h0, last[k]}, 0);
    check("idle_halted", {31'h0, halted[k]}, 0);
    check("idle_done", {31'h0, done[k]}, 0);
  endtask

  // Holds pc constant, lets the instance halt and dump, and checks every streamed word.
  task automatic run_dump(input int k, input int n, input logic [7:0] start,
                          input int stall_word, input int stall_len, input bit do_rst);
    int first_rd  = -1;
    int first_vld = -1;
    int halt_cyc  = -1;
    int done_cyc  = -1;
    int rd_cnt    = 0;
    int w         = 0;
    int rem       = stall_len;
    logic [7:0] ea;
    pc     = 32'h1c;
    rdy[k] = 1'b1;
    if (do_rst) begin
      rst[k] = 1'b1;
      tick();
      tick();
    end
    rst[k] = 1'b0;
    for (int c = 0; c < 300 && done_cyc < 0; c++) begin
      tick();
      if (halted[k] && halt_cyc < 0) halt_cyc = c;
      if (rd_en[k]) begin
        if (first_rd < 0) first_rd = c;
        ea = start + 8'(rd_cnt);
        check("rd_addr", {24'h0, rd_addr[k]}, {24'h0, ea});
        rd_cnt++;
      end
      if (valid[k]) begin
        if (first_vld < 0) first_vld = c;
        ea = start + 8'(w);
        check("no_rd_in_present", {31'h0, rd_en[k]}, 0);
        check("out_addr", {24'h0, oaddr[k]}, {24'h0, ea});
        check("out_data", odata[k], 32'hA000_0000 + {24'h0, ea});
        check("out_last", {31'h0, last[k]}, (w == n - 1) ? 1 : 0);
        if (w == stall_word && rem > 0) begin
          rdy[k] = 1'b0;
          rem--;
        end else begin
          rdy[k] = 1'b1;
          w++;
        end
      end
      if (done[k]) done_cyc = c;
    end
    check("done_seen", (done_cyc >= 0) ? 1 : 0, 1);
    check("word_count", w, n);
    check("read_count", rd_cnt, n);
    check("halt_with_issue", halt_cyc, first_rd);
    check("rd_to_valid", first_vld - first_rd, 2);
    check("rd_to_done", done_cyc - first_rd, 3 * n + stall_len);
    pc = 32'h200;
    tick();
    check("done_sticky", {31'h0, done[k]}, 1);
    check("done_no_valid", {31'h0, valid[k]}, 0);
    check("done_no_rd", {31'h0, rd_en[k]}, 0);
    check("halted_sticky", {31'h0, halted[k]}, 1);
  endtask

  initial begin
    int w;
    bit found;
    rst = 3'b111;
    pc  = 32'h0;
    rdy = 3'b111;
    tick();
    tick();
    for (int k = 0; k < 3; k++) check_idle(k);

    // Halt-detection vectors on the default instance.
    vt.push_back(mk(1'b1, 32'h00, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 32'h00, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 32'h00, 1'b0, 1'b0)); // post-reset cycle: load only
    vt.push_back(mk(1'b0, 32'h00, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 32'h00, 1'b1, 1'b1));
    vt.push_back(mk(1'b0, 32'h40, 1'b1, 1'b0));
    vt.push_back(mk(1'b0, 32'h44, 1'b1, 1'b0));
    vt.push_back(mk(1'b1, 32'h00, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 32'h00, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 32'h04, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 32'h08, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 32'h1c, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 32'h1c, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 32'h1c, 1'b1, 1'b1));
    vt.push_back(mk(1'b1, 32'h00, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 32'h10, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 32'h10, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 32'h14, 1'b0, 1'b0)); // change clears the counter
    vt.push_back(mk(1'b0, 32'h14, 1'b0, 1'b0));
    vt.push_back(mk(1'b0, 32'h14, 1'b1, 1'b1));
    vt.push_back(mk(1'b1, 32'h00, 1'b0, 1'b0));
    for (int i = 0; i < vt.size(); i++) begin
      rst[0] = vt[i].rst;
      pc     = vt[i].pc;
      tick();
      check($sformatf("vec%0d_halted", i), {31'h0, halted[0]}, {31'h0, vt[i].exp_halted});
      check($sformatf("vec%0d_rd_en", i), {31'h0, rd_en[0]}, {31'h0, vt[i].exp_rd_en});
    end

    run_dump(0, 8, 8'h00, -1, 0, 1'b1);
    run_dump(0, 8, 8'h00, 3, 5, 1'b1);

    // Reset while word 2 is being presented, then a fresh halt restarts the dump.
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    pc     = 32'h1c;
    rdy[0] = 1'b1;
    w      = 0;
    found  = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      tick();
      if (valid[0]) begin
        if (w == 2) found = 1'b1;
        else w++;
      end
    end
    check("mid_reach_word2", {31'h0, found}, 1);
    rst[0] = 1'b1;
    rdy[0] = 1'b0;
    tick();
    check_idle(0);
    run_dump(0, 8, 8'h00, -1, 0, 1'b0);

    run_dump(1, 4, 8'hFE, -1, 0, 1'b1);
    run_dump(2, 1, 8'h05, -1, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
